// File: rtl/mmio_led_pwm_if.sv
// Data-memory store/read bus as seen by an MMIO responder.
// The master drives the store strobe; the slave returns registered read data and hit.
interface mmio_led_pwm_if;
  logic [2:0]  funct3;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  logic        hit;

  modport master (
    output funct3, dmem_wren, dmem_address, dmem_data_in,
    input  dmem_data_out, hit
  );

  modport slave (
    input  funct3, dmem_wren, dmem_address, dmem_data_in,
    output dmem_data_out, hit
  );
endinterface

// File: rtl/mmio_led_pwm.sv
// Memory-mapped 4-channel LED PWM: duty/prescaler registers on the dmem bus,
// duty changes take effect only at the start of a 256-tick PWM period.

module mmio_led_pwm_ch #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VEC_W-1:0] pwm_cnt,
  input  logic [VEC_W-1:0] duty,
  output logic             pwm_out
);
  // All-ones duty is forced high so full scale never shows a one-tick low gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_out <= 1'b0;
    else        pwm_out <= (pwm_cnt < duty) || (duty == {VEC_W{1'b1}});
  end
endmodule

module mmio_led_pwm #(
  parameter logic [31:0] LED_ADDR    = 32'hFFFFFFFC,
  parameter logic [31:0] PRESC_ADDR  = 32'hFFFFFFF8,
  parameter logic [15:0] PRESC_RESET = 16'd46
) (
  input  logic           clk,
  input  logic           reset,
  mmio_led_pwm_if.slave  bus,
  output logic           led,
  output logic           red,
  output logic           green,
  output logic           blue
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  logic [NUM_LANES-1:0][VEC_W-1:0] duty_shadow, duty_active;
  logic [15:0]          presc, presc_cnt;
  logic [VEC_W-1:0]     pwm_cnt;
  logic                 tick;
  logic                 led_match, presc_match;
  logic [NUM_LANES-1:0] be;
  logic [31:0]          wdata;
  logic [NUM_LANES-1:0] pwm_out;

  assign led_match   = bus.dmem_address[31:2] == LED_ADDR[31:2];
  assign presc_match = bus.dmem_address[31:2] == PRESC_ADDR[31:2];
  assign tick        = presc_cnt >= presc;

  // Replicate store data across lanes so each byte enable picks its own byte.
  always_comb begin
    be    = '0;
    wdata = bus.dmem_data_in;
    case (bus.funct3)
      3'b000: begin
        be    = 4'b0001 << bus.dmem_address[1:0];
        wdata = {4{bus.dmem_data_in[7:0]}};
      end
      3'b001: if (!bus.dmem_address[0]) begin
        be    = bus.dmem_address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.dmem_data_in[15:0]}};
      end
      3'b010: if (bus.dmem_address[1:0] == 2'b00) be = 4'b1111;
      default: be = '0;
    endcase
    if (!bus.dmem_wren) be = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_shadow       <= '0;
      duty_active       <= '0;
      presc             <= PRESC_RESET;
      presc_cnt         <= '0;
      pwm_cnt           <= '0;
      bus.dmem_data_out <= '0;
      bus.hit           <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (led_match && be[i]) duty_shadow[i] <= wdata[8*i +: 8];
      for (int i = 0; i < 2; i++)
        if (presc_match && be[i]) presc[8*i +: 8] <= wdata[8*i +: 8];

      presc_cnt <= tick ? '0 : presc_cnt + 16'd1;
      // Active duty latches the pre-write shadow on the wrap tick.
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
        if (pwm_cnt == 8'hFF) duty_active <= duty_shadow;
      end

      bus.dmem_data_out <= led_match   ? duty_shadow :
                           presc_match ? {16'b0, presc} : 32'b0;
      bus.hit           <= led_match | presc_match;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
    mmio_led_pwm_ch #(.VEC_W(VEC_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .pwm_cnt (pwm_cnt),
      .duty    (duty_active[g]),
      .pwm_out (pwm_out[g])
    );
  end

  assign {led, red, green, blue} = pwm_out;
endmodule

// File: doc/mmio_led_pwm.md
Name: mmio_led_pwm

Overview:
- Memory-mapped LED peripheral: the responder end of the data-memory store bus (funct3/dmem_wren/dmem_address/dmem_data_in).
- Decodes CPU stores to the LED register and the prescaler register, holds per-channel 8-bit duty values, and generates glitch-free PWM on led/red/green/blue.
- Sits beside memory on the dmem bus; top inverts its outputs onto the active-low board pins.

Parameters:
- LED_ADDR, 32'hFFFFFFFC: word address of the duty register. Bits [31:24]=led, [23:16]=red, [15:8]=green, [7:0]=blue.
- PRESC_ADDR, 32'hFFFFFFF8: word address of the prescaler register. Bits [15:0] used, [31:16] read 0.
- PRESC_RESET, 16'd46: prescaler reload value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- funct3  input  3  store width: 000 byte, 001 half, 010 word
- dmem_wren  input  1  write strobe, one cycle per store
- dmem_address  input  32  byte address
- dmem_data_in  input  32  store data, right-aligned (byte/half in low bits)
- dmem_data_out  output  32  registered read data for the addressed register
- hit  output  1  registered; 1 when the previous-cycle address matched either register word
- led  output  1  PWM, active-high
- red  output  1  PWM, active-high
- green  output  1  PWM, active-high
- blue  output  1  PWM, active-high

Behaviour:
- Reset (reset=0, async): duty_shadow=0, duty_active=0, presc=PRESC_RESET, presc_cnt=0, pwm_cnt=0, dmem_data_out=0, hit=0, all PWM outputs 0.
- Decode: word match means dmem_address[31:2] equals the register's [31:2]. Byte lane is dmem_address[1:0].
- Write, funct3=000: store dmem_data_in[7:0] into lane addr[1:0].
- Write, funct3=001: requires addr[0]=0. Store [15:0] into lanes {addr[1],0}..{addr[1],1}.
- Write, funct3=010: requires addr[1:0]=00. Store all 32 bits.
- Ignored writes (no state change): misaligned stores, any other funct3 value, and non-matching addresses.
- Duty writes update duty_shadow only. Prescaler writes update presc immediately; presc_cnt is not disturbed.
- Read: dmem_data_out <= selected register, valid the cycle after the address. Selection is duty_shadow for LED_ADDR, {16'b0,presc} for PRESC_ADDR, 0 otherwise. Independent of dmem_wren.
- Write-then-read of the same register the next cycle returns the new value.
- Tick generation: presc_cnt counts up each clk. When presc_cnt >= presc, tick=1 and presc_cnt <= 0. presc=0 gives a tick every clk.
- PWM counter: pwm_cnt (8-bit) increments on tick and wraps 255->0.
- Period boundary (tick while pwm_cnt==255): duty_active <= duty_shadow. Duty changes therefore take effect only at a period start; no partial periods.
- Write coinciding with a boundary: the new value is loaded into duty_shadow that cycle. duty_active takes the old shadow; the new value applies one period later.
- Output per channel: out <= (pwm_cnt < duty_active[ch]) || (duty_active[ch]==8'hFF), registered.
  - Duty 0 is constant low.
  - Duty FF is constant high.
  - Duty N is high for N ticks of every 256.
- Reset mid-period: outputs drop to 0 immediately (async). Operation restarts from pwm_cnt=0 with duty 0 after reset release.
- State machine per period: LOAD (pwm_cnt==0, duty_active just loaded) -> ON (pwm_cnt<duty) -> OFF -> wraps to LOAD. Implemented via counter compare, not an explicit FSM.

Test Plan:
- Reset: hold reset=0 with toggling inputs -> all outputs 0. After release, a read of PRESC_ADDR returns 32'h0000002E with hit=1 one cycle later.
- Word store: SW 32'hFFFF0000 to FFFFFFFC, then presc=0 -> after the current period ends, led and red constant 1, green and blue constant 0.
- Sub-word stores: SB 8'h80 to FFFFFFFC (lane 0) then SH 16'h1234 to FFFFFFFE -> readback 32'h12340080.
  - Then presc=0: blue high for exactly 128 of every 256 clks.
- Illegal stores: SW to FFFFFFFD, SH to FFFFFFFD, funct3=100 store, store to FFFFFFF0 -> registers unchanged. hit=0 for FFFFFFF0.
- Boundary coherence: with duty blue=8'h40, write blue=8'hC0 mid-period -> the current period keeps 64 high ticks, the next period shows 192.
  - Second case: the same write landing on the pwm_cnt==255 tick -> the following period still shows 64, the one after shows 192.
- Prescaler: presc=3 -> tick every 4 clks, PWM period 1024 clks. Change presc to 0 mid-run -> the period shortens to 256 clks with no counter reset.
